// File: rtl/truth_table_sweeper.sv
// Drives a 4-input gate network through all 16 rows, assembles the
// sampled truth table and compares it against an expected function code.
module truth_table_sweeper #(
  parameter logic [15:0] EXPECTED      = 16'hA960,
  parameter int          SETTLE_CYCLES = 4,
  parameter int          CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        dut_out,
  output logic        in1,
  output logic        in2,
  output logic        in3,
  output logic        in4,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [4:0]  mismatch_count,
  output logic [3:0]  first_fail_idx,
  output logic        fail_valid
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic             sync_q1;
  logic             sync_out;
  logic [3:0]       idx;
  logic [3:0]       vec;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_pos;
  logic             row_bad;

  assign {in1, in2, in3, in4} = vec;
  assign bit_pos = 4'd15 - idx;
  assign row_bad = sync_out != EXPECTED[bit_pos];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1  <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      sync_q1  <= dut_out;
      sync_out <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (start && !abort) state_nxt = SETTLE;
      SETTLE:
        if (abort)            state_nxt = IDLE;
        else if (cnt == '0)   state_nxt = SAMPLE;
      SAMPLE:
        if (abort)            state_nxt = IDLE;
        else if (idx == 4'hF) state_nxt = DONE;
        else                  state_nxt = SETTLE;
      DONE:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      signature      <= '0;
      mismatch_count <= '0;
      first_fail_idx <= '0;
      fail_valid     <= 1'b0;
      cnt            <= '0;
      idx            <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            signature      <= '0;
            mismatch_count <= '0;
            first_fail_idx <= '0;
            fail_valid     <= 1'b0;
            pass           <= 1'b0;
            idx            <= '0;
            vec            <= '0;
            cnt            <= CNT_LOAD;
            busy           <= 1'b1;
          end
        end
        SETTLE: begin
          if (abort) begin
            busy <= 1'b0;
            vec  <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            busy <= 1'b0;
            vec  <= '0;
          end else begin
            signature[bit_pos] <= sync_out;
            if (row_bad) begin
              mismatch_count <= mismatch_count + 5'd1;
              if (!fail_valid) begin
                first_fail_idx <= idx;
                fail_valid     <= 1'b1;
              end
            end
            if (idx == 4'hF) begin
              // pass must include the row-15 compare happening this cycle
              done <= 1'b1;
              busy <= 1'b0;
              pass <= (mismatch_count == '0) && !row_bad;
            end else begin
              idx <= idx + 4'd1;
              vec <= idx + 4'd1;
              cnt <= CNT_LOAD;
            end
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: golden and stuck-at circuit models, abort, ignored
// restarts and mid-sweep reset.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        dut_out;
  logic        in1, in2, in3, in4;
  logic        busy, done, pass;
  logic [15:0] signature;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_fail_idx;
  logic        fail_valid;

  int checks = 0;
  int failures = 0;
  int lat;
  int done_seen;
  int mode = 0;
  logic [15:0] gold = 16'hA960;
  logic [3:0]  row;

  always #5 clk = ~clk;

  assign row = {in1, in2, in3, in4};
  assign dut_out = (mode == 0) ? gold[4'd15 - row] : (mode == 2);

  truth_table_sweeper dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .dut_out(dut_out),
    .in1(in1),
    .in2(in2),
    .in3(in3),
    .in4(in4),
    .busy(busy),
    .done(done),
    .pass(pass),
    .signature(signature),
    .mismatch_count(mismatch_count),
    .first_fail_idx(first_fail_idx),
    .fail_valid(fail_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_vec"}, {28'd0, row}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
    chk({tag, "_sig"}, {16'd0, signature}, 32'd0);
    chk({tag, "_mc"}, {27'd0, mismatch_count}, 32'd0);
    chk({tag, "_ffi"}, {28'd0, first_fail_idx}, 32'd0);
    chk({tag, "_fv"}, {31'd0, fail_valid}, 32'd0);
  endtask

  // Starts a sweep; extra start pulses may be issued at edge counts xa/xb.
  // lat = edges after the start edge at which done is seen, -1 on timeout.
  task automatic sweep(input int xa, input int xb, output int l);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    l = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      start = (n == xa || n == xb);
      if (done) begin
        l = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [15:0] sig,
                              input int mc, input int ffi, input logic fv,
                              input logic ps);
    chk({tag, "_lat"}, lat, 32'd80);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sig"}, {16'd0, signature}, {16'd0, sig});
    chk({tag, "_mc"}, {27'd0, mismatch_count}, mc);
    chk({tag, "_ffi"}, {28'd0, first_fail_idx}, ffi);
    chk({tag, "_fv"}, {31'd0, fail_valid}, {31'd0, fv});
    chk({tag, "_pass"}, {31'd0, pass}, {31'd0, ps});
    chk({tag, "_vec"}, {28'd0, row}, 32'hF);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_pass_hold"}, {31'd0, pass}, {31'd0, ps});
  endtask

  initial begin
    #2;
    chk_idle_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    mode = 0;
    sweep(0, 0, lat);
    check_result("golden", 16'hA960, 0, 0, 1'b0, 1'b1);

    mode = 1;
    sweep(0, 0, lat);
    check_result("stuck0", 16'h0000, 6, 0, 1'b1, 1'b0);

    mode = 2;
    sweep(0, 0, lat);
    check_result("stuck1", 16'hFFFF, 10, 1, 1'b1, 1'b0);

    // abort mid-sweep
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_vec", {28'd0, row}, 32'd0);
    done_seen = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    chk("abort_no_done", done_seen, 32'd0);
    chk("abort_pass", {31'd0, pass}, 32'd0);
    chk("abort_busy_idle", {31'd0, busy}, 32'd0);

    sweep(0, 0, lat);
    check_result("after_abort", 16'hA960, 0, 0, 1'b0, 1'b1);

    // abort and start together in IDLE: no sweep
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abort_wins_busy", {31'd0, busy}, 32'd0);
    chk("abort_wins_pass", {31'd0, pass}, 32'd1);

    // extra start pulses while busy
    mode = 2;
    sweep(10, 50, lat);
    check_result("restart_ign", 16'hFFFF, 10, 1, 1'b1, 1'b0);

    // reset mid-sweep
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle_zero("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    sweep(0, 0, lat);
    check_result("after_rst", 16'hA960, 0, 0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
